// File: rtl/lp_piped_int_div_mgr.sv
// Pipelined restoring integer divider. Results leave through an arrive/accept_n handshake.
// Stalled slots hold their contents, and empty slots pull work forward to close bubbles.
module lp_piped_int_div_mgr #(
    parameter  int WIDTH    = 16,
    parameter  int STAGES   = 4,
    parameter  int ID_WIDTH = 8,
    parameter  int TC_MODE  = 0,
    localparam int CW       = $clog2(STAGES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                launch,
    input  logic [ID_WIDTH-1:0] launch_id,
    input  logic                ovf_clr,
    input  logic                accept_n,
    output logic [WIDTH-1:0]    quotient,
    output logic [WIDTH-1:0]    remainder,
    output logic [1:0]          status,
    output logic                arrive,
    output logic [ID_WIDTH-1:0] arrive_id,
    output logic                push_out_n,
    output logic                pipe_full,
    output logic                pipe_ovf,
    output logic [CW-1:0]       pipe_census
);

    localparam int BPS = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // qd starts as the dividend magnitude; dividend bits shift out of the top
    // while quotient bits shift in at the bottom.
    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
        logic [WIDTH-1:0]    rem;
        logic [WIDTH-1:0]    qd;
        logic [WIDTH-1:0]    dv;
        logic                neg_q;
        logic                neg_r;
        logic                dbz;
        logic                sovf;
    } slot_t;

    slot_t          slot_q [STAGES];
    slot_t          slot_d [STAGES];
    slot_t          src    [STAGES];
    slot_t          entry;
    slot_t          last;
    logic [STAGES-1:0] go;
    logic           consume;
    logic           go_n;
    logic           a_neg;
    logic           b_neg;
    logic           ovf_q, ovf_d;
    logic [CW-1:0]  census_q, census_d;

    function automatic slot_t step_slot(input slot_t s);
        slot_t      r;
        logic [WIDTH:0] sh;
        logic       fits;
        r = s;
        for (int i = 0; i < BPS; i++) begin
            sh   = {r.rem, r.qd[WIDTH-1]};
            fits = (sh >= {1'b0, r.dv});
            r.rem = fits ? (sh[WIDTH-1:0] - r.dv) : sh[WIDTH-1:0];
            r.qd  = {r.qd[WIDTH-2:0], fits};
        end
        return r;
    endfunction

    // With a zero divisor the raw dividend goes in unsigned. The restoring loop
    // then leaves all-ones in the quotient and the dividend in the remainder.
    always_comb begin
        a_neg       = (TC_MODE != 0) && a[WIDTH-1];
        b_neg       = (TC_MODE != 0) && b[WIDTH-1];
        entry       = '0;
        entry.valid = launch;
        entry.id    = launch_id;
        entry.dbz   = (b == '0);
        entry.sovf  = (TC_MODE != 0) && (a == MIN_NEG) && (b == '1);
        entry.neg_q = !entry.dbz && (a_neg ^ b_neg);
        entry.neg_r = !entry.dbz && a_neg;
        entry.qd    = (a_neg && !entry.dbz) ? -a : a;
        entry.dv    = b_neg ? -b : b;
        entry.rem   = '0;
    end

    assign last    = slot_q[STAGES-1];
    assign consume = last.valid & ~accept_n;

    // go[k]: slot k may take its upstream content this cycle.
    always_comb begin
        go   = '0;
        go_n = consume;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go[k] = ~slot_q[k].valid | go_n;
            go_n  = go[k];
        end
    end

    always_comb begin
        src[0] = entry;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = slot_q[k-1];
        end
        census_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            slot_d[k] = go[k] ? step_slot(src[k]) : slot_q[k];
            census_d  = census_d + CW'(slot_d[k].valid);
        end
        ovf_d = ovf_q;
        if (launch && !go[0]) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                slot_q[k] <= '0;
            end
            ovf_q    <= 1'b0;
            census_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                slot_q[k] <= slot_d[k];
            end
            ovf_q    <= ovf_d;
            census_q <= census_d;
        end
    end

    assign arrive      = last.valid;
    assign arrive_id   = last.valid ? last.id : '0;
    assign quotient    = last.valid ? (last.neg_q ? -last.qd : last.qd) : '0;
    assign remainder   = last.valid ? (last.neg_r ? -last.rem : last.rem) : '0;
    assign status      = last.valid ? {last.sovf, last.dbz} : 2'b00;
    assign push_out_n  = ~consume;
    assign pipe_full   = ~go[0];
    assign pipe_ovf    = ovf_q;
    assign pipe_census = census_q;

endmodule

// File: tb/tb_lp_piped_int_div_mgr.sv
// Bench for lp_piped_int_div_mgr: an unsigned and a signed instance share the same stimulus.
// Both are checked every cycle against a queue-based occupancy model and an arithmetic reference.
module tb_lp_piped_int_div_mgr;

    localparam int W  = 16;
    localparam int S  = 4;
    localparam int IW = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b;
    logic          launch;
    logic [IW-1:0] launch_id;
    logic          ovf_clr;
    logic          accept_n;

    logic [W-1:0]  quotient_u, remainder_u, quotient_s, remainder_s;
    logic [1:0]    status_u, status_s;
    logic          arrive_u, arrive_s, push_out_n_u, push_out_n_s;
    logic          pipe_full_u, pipe_full_s, pipe_ovf_u, pipe_ovf_s;
    logic [IW-1:0] arrive_id_u, arrive_id_s;
    logic [CW-1:0] census_u, census_s;

    lp_piped_int_div_mgr #(.WIDTH(W), .STAGES(S), .ID_WIDTH(IW), .TC_MODE(0)) u_dut_u (
        .clk(clk), .rst(rst), .a(a), .b(b), .launch(launch), .launch_id(launch_id),
        .ovf_clr(ovf_clr), .accept_n(accept_n), .quotient(quotient_u),
        .remainder(remainder_u), .status(status_u), .arrive(arrive_u),
        .arrive_id(arrive_id_u), .push_out_n(push_out_n_u), .pipe_full(pipe_full_u),
        .pipe_ovf(pipe_ovf_u), .pipe_census(census_u)
    );

    lp_piped_int_div_mgr #(.WIDTH(W), .STAGES(S), .ID_WIDTH(IW), .TC_MODE(1)) u_dut_s (
        .clk(clk), .rst(rst), .a(a), .b(b), .launch(launch), .launch_id(launch_id),
        .ovf_clr(ovf_clr), .accept_n(accept_n), .quotient(quotient_s),
        .remainder(remainder_s), .status(status_s), .arrive(arrive_s),
        .arrive_id(arrive_id_s), .push_out_n(push_out_n_s), .pipe_full(pipe_full_s),
        .pipe_ovf(pipe_ovf_s), .pipe_census(census_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        int            p;
    } op_t;

    op_t  pipe_m[$];
    logic ovf_m;
    int   n_chk;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {status[1:0], quotient, remainder}.
    function automatic logic [33:0] ref_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input bit tc);
        int sa, sb, qi, ri;
        logic [33:0] res;
        if (bv == 0) begin
            res = {2'b01, 16'hFFFF, av};
        end else if (tc && av == 16'h8000 && bv == 16'hFFFF) begin
            res = {2'b10, 16'h8000, 16'h0000};
        end else if (!tc) begin
            res = {2'b00, av / bv, av % bv};
        end else begin
            sa  = $signed(av);
            sb  = $signed(bv);
            qi  = sa / sb;
            ri  = sa % sb;
            res = {2'b00, qi[15:0], ri[15:0]};
        end
        return res;
    endfunction

    // One clock cycle: drive inputs, check the combinational outputs against the model,
    // advance the model, then check the registered outputs after the edge.
    task automatic step(input logic l, input logic [IW-1:0] id, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic an, input logic oc, input logic r);
        op_t         nq[$];
        op_t         o;
        int          lim;
        logic        exp_arr, cons, can_launch;
        logic [33:0] ru, rs;
        logic [IW-1:0] exp_id;

        launch = l; launch_id = id; a = av; b = bv; accept_n = an; ovf_clr = oc; rst = r;
        #3;
        exp_arr = (pipe_m.size() > 0) && (pipe_m[0].p == S - 1);
        cons    = exp_arr && !an;
        ru      = '0;
        rs      = '0;
        exp_id  = '0;
        if (exp_arr) begin
            ru     = ref_div(pipe_m[0].a, pipe_m[0].b, 1'b0);
            rs     = ref_div(pipe_m[0].a, pipe_m[0].b, 1'b1);
            exp_id = pipe_m[0].id;
        end
        lim = S - 1;
        foreach (pipe_m[i]) begin
            if (i == 0 && cons) continue;
            o   = pipe_m[i];
            o.p = (o.p + 1 < lim) ? o.p + 1 : lim;
            nq.push_back(o);
            lim = o.p - 1;
        end
        can_launch = (lim >= 0);

        chk("arrive_u", arrive_u, exp_arr);
        chk("arrive_s", arrive_s, exp_arr);
        chk("arrive_id_u", arrive_id_u, exp_id);
        chk("arrive_id_s", arrive_id_s, exp_id);
        chk("quotient_u", quotient_u, ru[31:16]);
        chk("remainder_u", remainder_u, ru[15:0]);
        chk("status_u", status_u, ru[33:32]);
        chk("quotient_s", quotient_s, rs[31:16]);
        chk("remainder_s", remainder_s, rs[15:0]);
        chk("status_s", status_s, rs[33:32]);
        chk("push_out_n_u", push_out_n_u, !cons);
        chk("push_out_n_s", push_out_n_s, !cons);
        chk("pipe_full_u", pipe_full_u, !can_launch);
        chk("pipe_full_s", pipe_full_s, !can_launch);
        if (cons) begin
            $display("op id=%02h a=%04h b=%04h | u q=%04h r=%04h st=%0d | s q=%04h r=%04h st=%0d",
                     exp_id, pipe_m[0].a, pipe_m[0].b, quotient_u, remainder_u, status_u,
                     quotient_s, remainder_s, status_s);
        end

        if (r) begin
            pipe_m.delete();
            ovf_m = 1'b0;
        end else begin
            if (l && !can_launch) ovf_m = 1'b1;
            else if (oc)          ovf_m = 1'b0;
            if (l && can_launch) begin
                o.id = id; o.a = av; o.b = bv; o.p = 0;
                nq.push_back(o);
            end
            pipe_m = nq;
        end

        @(posedge clk);
        #1;
        chk("census_u", census_u, pipe_m.size());
        chk("census_s", census_s, pipe_m.size());
        chk("pipe_ovf_u", pipe_ovf_u, ovf_m);
        chk("pipe_ovf_s", pipe_ovf_s, ovf_m);
    endtask

    task automatic idle(input int n, input logic an);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 16'h0001, an, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        n_chk = 0;
        n_fail = 0;
        ovf_m = 1'b0;
        rst = 1'b1; launch = 1'b0; launch_id = '0; a = '0; b = '0;
        ovf_clr = 1'b0; accept_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("rst_census", census_u, 0);
        chk("rst_ovf", pipe_ovf_u, 0);
        chk("rst_arrive", arrive_u, 0);
        chk("rst_push_out_n", push_out_n_u, 1);
        chk("rst_full", pipe_full_s, 0);
        chk("rst_quotient", quotient_s, 0);
        @(posedge clk);
        #1;

        // Single operation, 4-cycle latency
        step(1'b1, 8'h5A, 16'd100, 16'd7, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);

        // Fill under stall, drop a fifth launch, drain, clear the sticky flag
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'h10 + 8'(i), 16'(1000 * (i + 1)), 16'(3 + i), 1'b1, 1'b0, 1'b0);
        chk("fill_census", census_u, 4);
        chk("fill_full", pipe_full_u, 1);
        step(1'b1, 8'h99, 16'd5, 16'd5, 1'b1, 1'b0, 1'b0);
        chk("drop_ovf", pipe_ovf_u, 1);
        idle(6, 1'b0);
        step(1'b0, '0, '0, 16'd1, 1'b0, 1'b1, 1'b0);
        chk("ovf_cleared", pipe_ovf_s, 0);

        // Bubble collapse under stall
        step(1'b1, 8'h01, 16'd50, 16'd6, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 16'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h02, 16'd77, 16'd9, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);
        chk("bubble_census", census_u, 2);
        chk("bubble_full", pipe_full_u, 0);
        idle(3, 1'b0);

        // Divide by zero, signed cases
        step(1'b1, 8'h03, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h04, 16'hFFF9, 16'h0002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h05, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);

        // Reset flush of a full pipe with the overflow flag set
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'h20 + 8'(i), 16'd900, 16'd4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h66, 16'd1, 16'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h77, 16'd2, 16'd1, 1'b1, 1'b0, 1'b1);
        chk("flush_census", census_u, 0);
        chk("flush_ovf", pipe_ovf_u, 0);
        chk("flush_arrive", arrive_s, 0);
        idle(6, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       rb = 16'h0000;
                1:       rb = 16'hFFFF;
                2:       rb = 16'h0001;
                3:       rb = 16'($urandom_range(1, 20));
                default: rb = 16'($urandom);
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            step($urandom_range(0, 9) < 7, 8'($urandom), ra, rb,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0);
        end
        idle(8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
